alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
// - Execute stage of the AsyncARM pipeline: pulls one decoded op from the decode stage via toggle/ready handshake.
// - Computes the ARM data-processing result and NZCV flags, then offers result, flags and destination index to writeback.
// - Sits between decode (upstream) and writeback (downstream).
// PARAMETERS
// - WIDTH      32            datapath width (only 32 supported)
// - CPSR_RST   32'h0000_0000 cpsrOut value after reset
// PORTS
// - clk        in   1   single clock, rising edge
// - reset      in   1   synchronous, active-high
// - dataIn1    in   32  operand A (Rn value)
// - dataIn2    in   32  operand B (shifted operand 2)
// - dataIn3    in   32  control: [3:0] opcode, [4] S bit, [5] shifter carry-out
// - dataIn4    in   32  current CPSR
// - typeIn     in   4   0=NOP, 1=data-processing, 2=MUL, others=NOP
// - srcDstIn   in   32  destination register index (passed through)
// - readyIn    in   1   decode data valid (level)
// - triggerOut out  1   toggled to request next op from decode
// - triggerIn  in   1   toggled by writeback to consume current result
// - readyOut   out  1   result valid (level)
// - dataOut1   out  32  ALU result
// - dataOut2   out  32  registered copy of dataIn2 (store data)
// - cpsrOut    out  32  updated CPSR
// - w          out  1   register write enable for writeback
// - srcDstOut  out  32  registered srcDstIn
// BEHAVIOUR
// - Reset: all outputs 0 except cpsrOut=CPSR_RST; internal triggerIn copy := triggerIn; state REQ.
// - REQ: toggle triggerOut, go ACK. ACK: wait readyIn==0, go WAIT. WAIT: on readyIn==1 latch inputs, compute, go DONE.
// - Entering DONE: readyOut=1 one cycle after latch; outputs stable while in DONE.
// - DONE: on triggerIn != stored copy: update copy, readyOut=0 next cycle, go REQ (triggerOut toggles the cycle after).
// - A triggerIn toggle outside DONE is recorded and honoured on entering DONE.
// - Reset in any state overrides everything; pending ops discarded.
// - Opcodes: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN (ARM encoding 0..15).
// - Arithmetic on 33 bits; C = carry out (subtract: C = NOT borrow); V = signed overflow; ADC/SBC/RSC use CPSR[29].
// - Logical ops: C = dataIn3[5], V unchanged.
// - N=res[31], Z=(res==0); flags written to CPSR[31:28] only if S=1 or opcode is TST/TEQ/CMP/CMN; other CPSR bits from dataIn4.
// - w=1 for data-processing except TST/TEQ/CMP/CMN (w=0, dataOut1 still = computed value).
// - NOP/unknown type: dataOut1=0, w=0, cpsrOut=dataIn4.
// CONFIGURATION
// - ALU_MUL_EN defined: typeIn=2 -> dataOut1 = low 32 bits of A*B, w=1; if S: N,Z updated, C,V kept.
// - ALU_MUL_EN undefined: typeIn=2 behaves as NOP.
// STRUCTURE
// - alu_pkg: opcode constants, type codes, CPSR flag bit positions, FSM state enum.
// - Sub-module alu_core: purely combinational result/flag compute.
// - Top: handshake FSM and output registers.
// TESTING
// - ADDS A=0x7FFFFFFF B=1 -> dataOut1=0x80000000, NZCV=1001, w=1, readyOut=1.
// - SUBS A=5 B=5 -> dataOut1=0, NZCV=0110.
// - CMP A=3 B=4 -> w=0, dataOut1=0xFFFFFFFF, NZCV=1000.
// - ADCS with CPSR C=1, A=0xFFFFFFFF B=0 -> dataOut1=0, NZCV=0110.
// - Handshake: triggerIn toggle in DONE -> readyOut 0, triggerOut toggles once; reset during WAIT -> all outputs reset values.
// - ALU_MUL_EN: typeIn=2, A=6 B=7 -> dataOut1=42, w=1; without macro -> w=0, dataOut1=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, op types, CPSR flag
// positions, handshake FSM states and the core result bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
        OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
        OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
        OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
    } alu_op_e;

    localparam logic [3:0] TYPE_NOP = 4'd0;
    localparam logic [3:0] TYPE_DP  = 4'd1;
    localparam logic [3:0] TYPE_MUL = 4'd2;

    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;

    localparam int CTRL_S   = 4;
    localparam int CTRL_SHC = 5;

    typedef enum logic [1:0] {ST_REQ, ST_ACK, ST_WAIT, ST_DONE} state_e;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] cpsr;
        logic        w;
    } alu_out_t;

    // Compare-class ops always set flags and never write a register
    function automatic logic is_test(alu_op_e op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decode-side and writeback-side handshake bundle of the execute stage.
// slave = execute stage, master = the environment around it.
interface alu_exec_stage_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] dataIn1;
    logic [WIDTH-1:0] dataIn2;
    logic [WIDTH-1:0] dataIn3;
    logic [WIDTH-1:0] dataIn4;
    logic [3:0]       typeIn;
    logic [WIDTH-1:0] srcDstIn;
    logic             readyIn;
    logic             triggerOut;
    logic             triggerIn;
    logic             readyOut;
    logic [WIDTH-1:0] dataOut1;
    logic [WIDTH-1:0] dataOut2;
    logic [WIDTH-1:0] cpsrOut;
    logic             w;
    logic [WIDTH-1:0] srcDstOut;

    modport slave (
        input  dataIn1, dataIn2, dataIn3, dataIn4, typeIn, srcDstIn, readyIn, triggerIn,
        output triggerOut, readyOut, dataOut1, dataOut2, cpsrOut, w, srcDstOut
    );

    modport master (
        output dataIn1, dataIn2, dataIn3, dataIn4, typeIn, srcDstIn, readyIn, triggerIn,
        input  triggerOut, readyOut, dataOut1, dataOut2, cpsrOut, w, srcDstOut
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ARM data-processing result and NZCV computation.
// Optional multiply support is enabled with the ALU_MUL_EN macro.
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  ctrl,
    input  logic [31:0] cpsr,
    input  logic [3:0]  typ,
    output alu_out_t    o
);

    alu_op_e     op;
    logic [31:0] x, y, lres, res;
    logic        ci, arith, c, v;
    logic [32:0] sum;
    logic [3:0]  nzcv;
`ifdef ALU_MUL_EN
    logic [31:0] prod;
`endif

    // Every arithmetic op is x + y + ci; subtracts invert one operand and
    // carry in 1 (or CPSR.C), so carry-out is already NOT borrow.
    always_comb begin
        op    = alu_op_e'(ctrl[3:0]);
        x     = a;
        y     = b;
        ci    = 1'b0;
        arith = 1'b1;
        lres  = '0;
        case (op)
            OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
            OP_RSB:         begin x = b; y = ~a; ci = 1'b1; end
            OP_ADD, OP_CMN: ;
            OP_ADC:         ci = cpsr[CPSR_C];
            OP_SBC:         begin y = ~b; ci = cpsr[CPSR_C]; end
            OP_RSC:         begin x = b; y = ~a; ci = cpsr[CPSR_C]; end
            OP_AND, OP_TST: begin arith = 1'b0; lres = a & b; end
            OP_EOR, OP_TEQ: begin arith = 1'b0; lres = a ^ b; end
            OP_ORR:         begin arith = 1'b0; lres = a | b; end
            OP_MOV:         begin arith = 1'b0; lres = b; end
            OP_BIC:         begin arith = 1'b0; lres = a & ~b; end
            OP_MVN:         begin arith = 1'b0; lres = ~b; end
            default:        arith = 1'b0;
        endcase
        sum  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        res  = arith ? sum[31:0] : lres;
        c    = arith ? sum[32] : ctrl[CTRL_SHC];
        v    = arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : cpsr[CPSR_V];
        nzcv = {res[31], (res == 32'd0), c, v};
    end

`ifdef ALU_MUL_EN
    assign prod = a * b;
`endif

    always_comb begin
        o.res  = '0;
        o.cpsr = cpsr;
        o.w    = 1'b0;
        case (typ)
            TYPE_DP: begin
                o.res = res;
                o.w   = !is_test(op);
                if (ctrl[CTRL_S] || is_test(op))
                    o.cpsr[CPSR_N:CPSR_V] = nzcv;
            end
`ifdef ALU_MUL_EN
            TYPE_MUL: begin
                o.res = prod;
                o.w   = 1'b1;
                if (ctrl[CTRL_S])
                    o.cpsr[CPSR_N:CPSR_Z] = {prod[31], (prod == 32'd0)};
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// AsyncARM execute stage: toggle/ready handshake FSM around alu_core with
// registered writeback outputs. Define ALU_MUL_EN to execute MUL ops.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] CPSR_RST = '0
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_stage_if.slave bus
);

    state_e      state;
    logic        trig_copy;
    logic        trig_out_q;
    logic        ready_q;
    logic        w_q;
    logic [31:0] res_q, d2_q, cpsr_q, sd_q;
    alu_out_t    core_o;
    logic        unused_ctrl;

    assign unused_ctrl = ^bus.dataIn3[31:6];

    alu_core u_core (
        .a    (bus.dataIn1),
        .b    (bus.dataIn2),
        .ctrl (bus.dataIn3[5:0]),
        .cpsr (bus.dataIn4),
        .typ  (bus.typeIn),
        .o    (core_o)
    );

    // trig_copy only advances in DONE, so a writeback toggle seen earlier
    // stays pending and releases DONE on its first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_REQ;
            trig_copy  <= bus.triggerIn;
            trig_out_q <= 1'b0;
            ready_q    <= 1'b0;
            w_q        <= 1'b0;
            res_q      <= '0;
            d2_q       <= '0;
            cpsr_q     <= CPSR_RST;
            sd_q       <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    trig_out_q <= ~trig_out_q;
                    state      <= ST_ACK;
                end
                ST_ACK: begin
                    if (!bus.readyIn)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.readyIn) begin
                        res_q   <= core_o.res;
                        cpsr_q  <= core_o.cpsr;
                        w_q     <= core_o.w;
                        d2_q    <= bus.dataIn2;
                        sd_q    <= bus.srcDstIn;
                        ready_q <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.triggerIn != trig_copy) begin
                        trig_copy <= bus.triggerIn;
                        ready_q   <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    assign bus.triggerOut = trig_out_q;
    assign bus.readyOut   = ready_q;
    assign bus.dataOut1   = res_q;
    assign bus.dataOut2   = d2_q;
    assign bus.cpsrOut    = cpsr_q;
    assign bus.w          = w_q;
    assign bus.srcDstOut  = sd_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: a decode driver issues ops, expected
// results from an independent arithmetic model are queued and popped on readyOut.
module tb_alu_exec_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_exec_stage_if #(.WIDTH(32)) bus ();

    alu_exec_stage #(.WIDTH(32), .CPSR_RST(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] d2;
        logic [31:0] cpsr;
        logic [31:0] sd;
        logic        w;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic last_trig = 1'b0;

    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [31:0] ctrl,
                                   logic [31:0] cpsr, logic [3:0] typ, logic [31:0] sd);
        exp_t        e;
        logic [3:0]  op;
        logic        s, tst, c, v, ci;
        logic [31:0] r, x, y, p;
        logic [63:0] ufull;
        longint      ux, uy, sx, sy, sr, dif, lbw;
        e.d2 = b; e.sd = sd; e.cpsr = cpsr; e.res = 32'd0; e.w = 1'b0;
        op = ctrl[3:0]; s = ctrl[4]; tst = (op >= 4'd8) && (op <= 4'd11);
        ci = cpsr[29]; c = ctrl[5]; v = cpsr[28]; r = 32'd0;
        case (op)
            4'd0, 4'd8: r = a & b;
            4'd1, 4'd9: r = a ^ b;
            4'd12:      r = a | b;
            4'd13:      r = b;
            4'd14:      r = a & ~b;
            4'd15:      r = ~b;
            4'd4, 4'd5, 4'd11: begin
                lbw   = {63'd0, (op == 4'd5) ? ci : 1'b0};
                ufull = {32'd0, a} + {32'd0, b} + lbw;
                r = ufull[31:0]; c = ufull[32];
                sx = $signed(a); sy = $signed(b); sr = sx + sy + lbw;
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            default: begin
                x   = (op == 4'd3 || op == 4'd7) ? b : a;
                y   = (op == 4'd3 || op == 4'd7) ? a : b;
                lbw = {63'd0, (op == 4'd6 || op == 4'd7) ? !ci : 1'b0};
                ux = {32'd0, x}; uy = {32'd0, y};
                dif = ux - uy - lbw;
                r = dif[31:0]; c = (dif >= 0);
                sx = $signed(x); sy = $signed(y); sr = sx - sy - lbw;
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
        endcase
        if (typ == 4'd1) begin
            e.res = r; e.w = !tst;
            if (s || tst) e.cpsr[31:28] = {r[31], r == 32'd0, c, v};
        end
`ifdef ALU_MUL_EN
        if (typ == 4'd2) begin
            p = a * b;
            e.res = p; e.w = 1'b1;
            if (s) e.cpsr[31:30] = {p[31], p == 32'd0};
        end
`endif
        return e;
    endfunction

    task automatic wait_trig();
        int n = 0;
        while (bus.triggerOut === last_trig && n < 40) begin
            @(negedge clk); n++;
        end
        checks++;
        if (bus.triggerOut === last_trig) begin
            errors++;
            $display("FAIL trig_request: triggerOut=%b stayed, wanted toggle", bus.triggerOut);
        end
        last_trig = bus.triggerOut;
    endtask

    task automatic issue(logic [31:0] a, logic [31:0] b, logic [31:0] ctrl,
                         logic [31:0] cpsr, logic [3:0] typ, logic [31:0] sd);
        wait_trig();
        bus.readyIn = 1'b0;
        repeat (2) @(negedge clk);
        bus.dataIn1 = a; bus.dataIn2 = b; bus.dataIn3 = ctrl;
        bus.dataIn4 = cpsr; bus.typeIn = typ; bus.srcDstIn = sd;
        bus.readyIn = 1'b1;
        sb.push_back(model(a, b, ctrl, cpsr, typ, sd));
    endtask

    task automatic consume(string name);
        exp_t e;
        int   n = 0;
        while (bus.readyOut !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        e = sb.pop_front();
        checks++;
        if (bus.readyOut !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: readyOut=%b want 1", name, bus.readyOut);
            return;
        end
        checks++;
        if (bus.dataOut1 !== e.res) begin
            errors++; $display("FAIL %s_res: got %h want %h", name, bus.dataOut1, e.res);
        end
        checks++;
        if (bus.cpsrOut !== e.cpsr) begin
            errors++; $display("FAIL %s_cpsr: got %h want %h", name, bus.cpsrOut, e.cpsr);
        end
        checks++;
        if (bus.w !== e.w) begin
            errors++; $display("FAIL %s_w: got %b want %b", name, bus.w, e.w);
        end
        checks++;
        if (bus.dataOut2 !== e.d2 || bus.srcDstOut !== e.sd) begin
            errors++;
            $display("FAIL %s_pass: d2 %h/%h sd %h/%h", name, bus.dataOut2, e.d2, bus.srcDstOut, e.sd);
        end
        bus.triggerIn = ~bus.triggerIn;
        n = 0;
        @(negedge clk);
        while (bus.readyOut !== 1'b0 && n < 40) begin
            @(negedge clk); n++;
        end
        checks++;
        if (bus.readyOut !== 1'b0) begin
            errors++; $display("FAIL %s_release: readyOut=%b want 0", name, bus.readyOut);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.readyOut !== 1'b0 || bus.triggerOut !== 1'b0 || bus.dataOut1 !== 32'd0 ||
            bus.cpsrOut !== 32'd0 || bus.w !== 1'b0 || bus.dataOut2 !== 32'd0 ||
            bus.srcDstOut !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b trg=%b d1=%h cpsr=%h w=%b d2=%h sd=%h",
                     bus.readyOut, bus.triggerOut, bus.dataOut1, bus.cpsrOut, bus.w,
                     bus.dataOut2, bus.srcDstOut);
        end
        last_trig = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_spec_vectors();
        issue(32'h7FFF_FFFF, 32'd1, 32'h14, 32'h0, 4'd1, 32'd3);  consume("adds_ovf");
        checks++;
        if (bus.cpsrOut[31:28] !== 4'b1001 || bus.dataOut1 !== 32'h8000_0000) begin
            errors++; $display("FAIL adds_const: nzcv=%b res=%h want 1001 80000000",
                               bus.cpsrOut[31:28], bus.dataOut1);
        end
        issue(32'd5, 32'd5, 32'h12, 32'h0, 4'd1, 32'd4);           consume("subs_zero");
        issue(32'd3, 32'd4, 32'h0A, 32'h0, 4'd1, 32'd5);           consume("cmp");
        issue(32'hFFFF_FFFF, 32'd0, 32'h15, 32'h2000_0000, 4'd1, 32'd6); consume("adcs");
    endtask

    task automatic test_logical();
        issue(32'hF0F0_1234, 32'h0FF0_FFFF, 32'h30, 32'h1000_0000, 4'd1, 32'd1); consume("ands");
        issue(32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h11, 32'h0, 4'd1, 32'd2);         consume("eors");
        issue(32'h0000_00F0, 32'h0000_000F, 32'h0C, 32'hF000_0000, 4'd1, 32'd7); consume("orr");
        issue(32'h0, 32'h8000_0001, 32'h1D, 32'h0, 4'd1, 32'd8);                 consume("movs");
        issue(32'hFFFF_FFFF, 32'h0000_FFFF, 32'h3E, 32'h0, 4'd1, 32'd9);         consume("bics");
        issue(32'h0, 32'hFFFF_FFFF, 32'h1F, 32'h1000_0000, 4'd1, 32'd10);        consume("mvns");
        issue(32'h0000_0F00, 32'h0000_00FF, 32'h08, 32'h3000_0000, 4'd1, 32'd11); consume("tst");
        issue(32'h1234_5678, 32'h1234_5678, 32'h29, 32'h1000_0000, 4'd1, 32'd12); consume("teq");
    endtask

    task automatic test_arith();
        issue(32'd10, 32'd3, 32'h13, 32'h0, 4'd1, 32'd13);                      consume("rsbs");
        issue(32'h8000_0000, 32'd1, 32'h16, 32'h0, 4'd1, 32'd14);               consume("sbcs_c0");
        issue(32'd1, 32'd1, 32'h17, 32'h2000_0000, 4'd1, 32'd15);               consume("rscs_c1");
        issue(32'h8000_0000, 32'h8000_0000, 32'h0B, 32'h0, 4'd1, 32'd16);       consume("cmn");
        issue(32'hFFFF_FFFF, 32'd2, 32'h04, 32'h5000_00AA, 4'd1, 32'd17);       consume("add_nos");
    endtask

    task automatic test_nop_mul();
        issue(32'd6, 32'd7, 32'h14, 32'hA000_0001, 4'd0, 32'd18);  consume("nop");
        issue(32'd6, 32'd7, 32'h10, 32'h6000_0000, 4'd2, 32'd19);  consume("mul");
        issue(32'd9, 32'd9, 32'h14, 32'h1234_5678, 4'd7, 32'd20);  consume("unknown");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            issue($urandom, $urandom, $urandom, $urandom, 4'($urandom_range(0, 3)), $urandom);
            consume("random");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        want = 32'h0000_1111 + 32'h0000_2222;
        wait_trig();
        bus.readyIn = 1'b0;
        @(negedge clk);
        bus.triggerIn = ~bus.triggerIn;
        @(negedge clk);
        bus.dataIn1 = 32'h0000_1111; bus.dataIn2 = 32'h0000_2222; bus.dataIn3 = 32'h04;
        bus.dataIn4 = 32'h0; bus.typeIn = 4'd1; bus.srcDstIn = 32'd21;
        bus.readyIn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.readyOut !== 1'b1 || bus.dataOut1 !== want) begin
            errors++; $display("FAIL early_toggle_done: rdy=%b res=%h want 1 %h",
                               bus.readyOut, bus.dataOut1, want);
        end
        @(negedge clk);
        checks++;
        if (bus.readyOut !== 1'b0) begin
            errors++; $display("FAIL early_toggle_release: readyOut=%b want 0", bus.readyOut);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.triggerOut !== ~last_trig) begin
            errors++; $display("FAIL single_toggle: triggerOut=%b want %b", bus.triggerOut, ~last_trig);
        end
    endtask

    task automatic test_reset_wait();
        wait_trig();
        bus.readyIn = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.readyOut !== 1'b0 || bus.triggerOut !== 1'b0 || bus.dataOut1 !== 32'd0 ||
            bus.cpsrOut !== 32'd0 || bus.w !== 1'b0 || bus.dataOut2 !== 32'd0 ||
            bus.srcDstOut !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_wait: rdy=%b trg=%b d1=%h cpsr=%h w=%b d2=%h sd=%h",
                     bus.readyOut, bus.triggerOut, bus.dataOut1, bus.cpsrOut, bus.w,
                     bus.dataOut2, bus.srcDstOut);
        end
        reset = 1'b0;
        last_trig = 1'b0;
        issue(32'd100, 32'd58, 32'h12, 32'h0, 4'd1, 32'd22);
        consume("after_reset");
    endtask

    initial begin
        bus.dataIn1 = '0; bus.dataIn2 = '0; bus.dataIn3 = '0; bus.dataIn4 = '0;
        bus.typeIn = '0; bus.srcDstIn = '0; bus.readyIn = 1'b0; bus.triggerIn = 1'b0;
        test_reset();
        test_spec_vectors();
        test_logical();
        test_arith();
        test_nop_mul();
        test_random();
        test_back_to_back();
        test_reset_wait();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
